// File: rtl/line_buffer_ctrl_pkg.sv
// Shared constants and FSM encoding for the line-buffer controller and its RAMs.
package line_buffer_ctrl_pkg;

  localparam int NUM_LINES = 4;
  localparam int WIN_LINES = 3;
  localparam int TAPS      = 3;
  localparam int SEL_W     = $clog2(NUM_LINES);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  function automatic int line_width(input int pixel_w);
    return TAPS * pixel_w;
  endfunction

  function automatic int win_width(input int pixel_w);
    return WIN_LINES * TAPS * pixel_w;
  endfunction

endpackage

// File: rtl/line_buffer_ctrl_line_buffer.sv
// Single image line: synchronous write, combinational 3-tap read with zero pad past the right edge.
module line_buffer
  import line_buffer_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH = 512,
  parameter int PIXEL_W     = 8
) (
  input  logic                                clk,
  input  logic                                wr_en,
  input  logic [$clog2(IMAGE_WIDTH)-1:0]      wr_col,
  input  logic [PIXEL_W-1:0]                  wr_data,
  input  logic [$clog2(IMAGE_WIDTH)-1:0]      rd_col,
  output logic [line_width(PIXEL_W)-1:0]      rd_data
);

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam logic [COL_W:0] COL_LIMIT = (COL_W+1)'(IMAGE_WIDTH);

  logic [PIXEL_W-1:0] mem [IMAGE_WIDTH];
  logic [COL_W:0]     idx;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_col] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    idx     = '0;
    for (int j = 0; j < TAPS; j++) begin
      idx = {1'b0, rd_col} + (COL_W+1)'(j);
      if (idx < COL_LIMIT) rd_data[j*PIXEL_W +: PIXEL_W] = mem[idx[COL_W-1:0]];
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Steers a raster pixel stream into four line RAMs and streams 3x3 windows once three lines are held.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int IMAGE_WIDTH = 512,
  parameter int PIXEL_W     = 8
) (
  input  logic                           axis_clk,
  input  logic                           axis_reset_n,
  input  logic                           i_pixel_data_valid,
  input  logic [PIXEL_W-1:0]             i_pixel_data,
  output logic [win_width(PIXEL_W)-1:0]  o_pixel_data,
  output logic                           o_pixel_data_valid,
  output logic                           o_intr
);

  localparam int COL_W  = $clog2(IMAGE_WIDTH);
  localparam int CNT_W  = $clog2(NUM_LINES*IMAGE_WIDTH) + 1;
  localparam int LINE_W = line_width(PIXEL_W);
  localparam int WIN_W  = win_width(PIXEL_W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_LINES*IMAGE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_RD   = CNT_W'(WIN_LINES*IMAGE_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH-1);

  state_t             state, next_state;
  logic [SEL_W-1:0]   wr_sel, rd_sel;
  logic [COL_W-1:0]   wr_col, rd_col;
  logic [CNT_W-1:0]   count;
  logic               wr_en, rd_en, rd_last, last_p1;
  logic [LINE_W-1:0]  line_data [NUM_LINES];
  logic [WIN_W-1:0]   window;

  // Writes are dropped while all four lines are still unread.
  assign wr_en   = i_pixel_data_valid && (count != CNT_FULL);
  assign rd_en   = (state == READ);
  assign rd_last = rd_en && (rd_col == COL_LAST);

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_lb
    line_buffer #(.IMAGE_WIDTH(IMAGE_WIDTH), .PIXEL_W(PIXEL_W)) u_lb (
      .clk     (axis_clk),
      .wr_en   (wr_en && (wr_sel == SEL_W'(i))),
      .wr_col  (wr_col),
      .wr_data (i_pixel_data),
      .rd_col  (rd_col),
      .rd_data (line_data[i])
    );
  end

  always_comb begin
    window = '0;
    for (int k = 0; k < WIN_LINES; k++) begin
      window[k*LINE_W +: LINE_W] = line_data[rd_sel + SEL_W'(k)];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (count >= CNT_RD) next_state = READ;
      READ:    if (rd_col == COL_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      state  <= IDLE;
      wr_sel <= '0;
      wr_col <= '0;
      rd_sel <= '0;
      rd_col <= '0;
      count  <= '0;
    end else begin
      state <= next_state;
      if (wr_en) begin
        if (wr_col == COL_LAST) begin
          wr_col <= '0;
          wr_sel <= wr_sel + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (rd_en) begin
        if (rd_last) begin
          rd_col <= '0;
          rd_sel <= rd_sel + 1'b1;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // p1: window register; interrupt trails the last valid window by one cycle
  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      last_p1            <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      o_pixel_data       <= rd_en ? window : '0;
      o_pixel_data_valid <= rd_en;
      last_p1            <= rd_last;
      o_intr             <= last_p1;
    end
  end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl at IMAGE_WIDTH=8, pixel value = line*16 + col.
module tb_line_buffer_ctrl;
  import line_buffer_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [PW-1:0] data = '0;
  logic [71:0]   o_data;
  logic          o_valid;
  logic          o_intr;

  int n_checks = 0;
  int n_err    = 0;

  logic [71:0] win_q [$];
  int intr_cnt = 0;
  int run      = 0;
  logic prev_vld = 1'b0;

  line_buffer_ctrl #(.IMAGE_WIDTH(W), .PIXEL_W(PW)) dut (
    .axis_clk           (clk),
    .axis_reset_n       (rst_n),
    .i_pixel_data_valid (valid),
    .i_pixel_data       (data),
    .o_pixel_data       (o_data),
    .o_pixel_data_valid (o_valid),
    .o_intr             (o_intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int base, input int col);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        if (col + j < W) w[k*24 + j*8 +: 8] = 8'((base + k) * 16 + col + j);
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      run      = 0;
      prev_vld = 1'b0;
    end else begin
      if (o_valid) begin
        win_q.push_back(o_data);
        run++;
      end
      if (o_intr) begin
        intr_cnt++;
        check("intr_after_last", {70'd0, prev_vld, o_valid}, 72'b10);
        check("run_len", 72'(run), 72'(W));
        run = 0;
      end
      prev_vld = o_valid;
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic push_px(input logic [PW-1:0] px);
    valid = 1'b1;
    data  = px;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic send_lines(input int first, input int last, input bit gaps);
    for (int l = first; l <= last; l++)
      for (int c = 0; c < W; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) sync();
        push_px(8'(l * 16 + c));
      end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) sync();
    rst_n = 1'b1;
  endtask

  task automatic wait_intr(input int target, input string tag);
    for (int i = 0; i < 400 && intr_cnt < target; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check(tag, 72'(intr_cnt), 72'(target));
  endtask

  initial begin
    int qb, ib, n;

    // reset state
    #1;
    check("rst_async_data", o_data, 72'd0);
    check("rst_async_vld", {71'd0, o_valid}, 72'd0);
    repeat (3) sync();
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_data", o_data, 72'd0);
    check("idle_vld", {71'd0, o_valid}, 72'd0);
    check("idle_intr", {71'd0, o_intr}, 72'd0);
    check("idle_fsm", {71'd0, dut.state}, {71'd0, IDLE});
    check("idle_nwin", 72'(win_q.size()), 72'd0);

    // lines 0-2 back-to-back, line 3 overlapping the first read pass
    qb = win_q.size();
    ib = intr_cnt;
    sync();
    send_lines(0, 3, 1'b0);
    wait_intr(ib + 2, "t2_intr_total");
    check("t2_nwin", 72'(win_q.size() - qb), 72'd16);
    if (win_q.size() >= qb + 16) begin
      check("t2_first", win_q[qb], 72'h222120_121110_020100);
      check("t2_last", win_q[qb+7], 72'h000027_000017_000007);
      check("t2_pass2_first", win_q[qb+8], 72'h323130_222120_121110);
      for (int i = 0; i < 16; i++) check("t2_win", win_q[qb+i], exp_win(i / W, i % W));
    end
    check("t2_count", 72'(dut.count), 72'd16);

    // lines 0-5 with random valid gaps
    do_reset();
    qb = win_q.size();
    ib = intr_cnt;
    send_lines(0, 5, 1'b1);
    wait_intr(ib + 4, "t3_intr_total");
    n = win_q.size() - qb;
    check("t3_nwin", 72'(n), 72'd32);
    if (n >= 32) begin
      check("t3_pass3_first", win_q[qb+16], 72'h424140_323130_222120);
      for (int i = 0; i < 32; i++) check("t3_win", win_q[qb+i], exp_win(i / W, i % W));
    end

    // four full lines held with reads blocked, then one extra pixel
    do_reset();
    qb = win_q.size();
    ib = intr_cnt;
    force dut.state = IDLE;
    send_lines(0, 3, 1'b0);
    @(negedge clk);
    check("full_count", 72'(dut.count), 72'd32);
    sync();
    push_px(8'hEE);
    @(negedge clk);
    check("drop_count", 72'(dut.count), 72'd32);
    check("drop_wr_col", 72'(dut.wr_col), 72'd0);
    check("drop_wr_sel", 72'(dut.wr_sel), 72'd0);
    check("drop_mem", 72'(dut.g_lb[0].u_lb.mem[0]), 72'h00);
    release dut.state;

    // reset asserted mid-clock while reading column 4
    for (int i = 0; i < 100 && !(dut.state == READ && dut.rd_col == 3'd4); i++) @(negedge clk);
    check("rd_col4", 72'(dut.rd_col), 72'd4);
    check("vld_before_rst", {71'd0, o_valid}, 72'd1);
    if (win_q.size() > qb) check("t4_first", win_q[qb], 72'h222120_121110_020100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {71'd0, o_valid}, 72'd0);
    check("mid_rst_intr", {71'd0, o_intr}, 72'd0);
    check("mid_rst_data", o_data, 72'd0);
    repeat (3) sync();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_trailing_intr", 72'(intr_cnt), 72'(ib));
    check("post_rst_count", 72'(dut.count), 72'd0);

    // refill after reset
    qb = win_q.size();
    sync();
    send_lines(0, 2, 1'b0);
    wait_intr(ib + 1, "t5_intr_total");
    check("t5_nwin", 72'(win_q.size() - qb), 72'd8);
    if (win_q.size() > qb) check("t5_first", win_q[qb], 72'h222120_121110_020100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Image-control stage sitting directly behind the AXI-stream slave input of the spatial filter top, and directly ahead of the 3x3 convolution core. It steers an incoming raster pixel stream round-robin into four line buffers. Whenever three full lines are stored, it reads them out together as a sliding 3x3 window (72 bits), one window per cycle. After each line is consumed it pulses an interrupt so the host can send the next line.

Parameters:
IMAGE_WIDTH, 512, pixels per image line (>=4)
PIXEL_W, 8, bits per pixel (window width = 9*PIXEL_W)

Ports:
axis_clk  in  1  clock; all logic on rising edge
axis_reset_n  in  1  reset; asynchronous assert, active-low
i_pixel_data_valid  in  1  input pixel strobe; one pixel accepted per cycle when high
i_pixel_data  in  PIXEL_W  input pixel, raster order
o_pixel_data  out  9*PIXEL_W  3x3 window to convolution core
o_pixel_data_valid  out  1  window valid strobe
o_intr  out  1  one-cycle pulse: one line buffer freed

Behaviour:
- Clocking/reset: one clock, axis_clk. Reset is asynchronous and active-low on axis_reset_n.
- Reset values: o_pixel_data=0, o_pixel_data_valid=0, o_intr=0. Also reset: write select, write column, read select, read column, stored-pixel count, FSM=IDLE. Line buffer RAM contents are not reset.
- Write side:
  - wr_sel (0..3) selects the target buffer; wr_col (0..W-1) is the write address.
  - On valid: write at wr_col, then increment wr_col. At W-1, wr_col wraps to 0 and wr_sel increments mod 4.
  - No valid: nothing changes. Valid gaps are allowed anywhere.
- Stored count: width clog2(4W)+1.
  - +1 on write only; -1 on read only; unchanged when both happen in the same cycle.
  - If count==4W, the write is dropped: no pointer change, no count change.
- Read FSM:
  - IDLE -> READ when count >= 3W, evaluated on the registered count.
  - READ: rd_en=1 every cycle; rd_col increments 0..W-1.
  - When rd_col==W-1 and reading: go to IDLE, rd_col=0, rd_sel increments mod 4, o_intr=1 for the next cycle only.
  - From IDLE, re-entry to READ takes effect no earlier than the cycle after the return to IDLE.
- Window format (column c = rd_col):
  - Lines: L0=buffer rd_sel (oldest), L1=rd_sel+1, L2=rd_sel+2, all mod 4.
  - Line Lk occupies bits [24k+23:24k] (for PIXEL_W=8). Within each line: [7:0]=col c, [15:8]=col c+1, [23:16]=col c+2.
  - Any column >= W reads as 0 (right-edge zero pad).
- Latency and output timing:
  - o_pixel_data and o_pixel_data_valid are registered, 1 cycle after rd_en.
  - W consecutive valid cycles per line, no bubbles.
  - o_intr coincides with the cycle after the last valid window.
- Simultaneous write and read of the same buffer cannot occur: at most 3 buffers are read and count <= 4W. No special handling is required.
- Reset mid-operation: all outputs drop on assertion, with no trailing valid or intr. After release, behaviour is as from power-up.

Decomposition:
- Shared package constants: NUM_LINES=4, WIN_LINES=3, pixel/window width localparams, FSM state enum {IDLE, READ}.
- One natural sub-module, line_buffer: a single-line RAM of IMAGE_WIDTH x PIXEL_W.
  - Synchronous write; combinational 3-pixel read at rd_col, rd_col+1, rd_col+2 with zero pad.
  - Instantiated 4 times; the controller muxes by rd_sel/wr_sel.

Test Plan (IMAGE_WIDTH=8, pixel = line*16+col, lines numbered from 0):
- Reset held then released, no input -> all outputs 0 and FSM IDLE for 50 cycles. Async assert mid-clock clears outputs without waiting for an edge.
- Write lines 0-2 back-to-back (24 pixels):
  - First valid window = 72'h222120_121110_020100.
  - 8 consecutive valid windows; last = 72'h000027_000017_000007.
  - o_intr exactly one pulse, one cycle after the last valid window.
- Write line 3 during the first read, with a write and a read in the same cycles:
  - Count stays consistent; second read pass begins after intr.
  - First window = 72'h323130_222120_121110.
- Write lines 0-5 with random valid gaps:
  - Windows unaffected by gaps.
  - Third pass uses buffers 2,3,0 (rd_sel wrap): first window = 72'h424140_323130_222120.
  - Exactly 4 intr pulses total (lines 0-5 yield 4 read passes).
- Hold four full lines (count=4W) without allowing reads (force FSM in bench) and drive an extra pixel -> pixel dropped, wr_sel/wr_col/count unchanged.
- Assert reset at read column 4 -> valid and intr low immediately, no intr pulse. Refill 3 lines -> first window again 72'h222120_121110_020100.
